// File: rtl/twiddle_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : twiddle_pkg
//  Description : Shared definitions for the twiddle-factor server: quarter-
//                wave cosine generator evaluated at elaboration, index-width
//                helper and the {re, im} coefficient pair type.
//  Revision    : 1.0 - initial release
// ============================================================================
package twiddle_pkg;

    // Widest coefficient the pair type can carry; real blocks use far less.
    localparam int c_coef_max_w = 32;

    typedef struct packed {
        logic signed [c_coef_max_w-1:0] re;
        logic signed [c_coef_max_w-1:0] im;
    } coef_pair_t;

    // Index width for an N-point FFT: indices span 0..N/2-1.
    function automatic int idx_w(input int n);
        return $clog2(n) - 1;
    endfunction

    // C[m] = round(cos(2*pi*m/n) * (2^(width-1)-1)), rounding half away from
    // zero. The scale leaves headroom so that negation can never overflow.
    function automatic int cos_q(input int m, input int n, input int width);
        real v;
        real s;
        s = real'((1 << (width - 1)) - 1);
        v = $cos(2.0 * 3.14159265358979323846 * real'(m) / real'(n)) * s;
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end
        return -$rtoi(0.5 - v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_factor_server_if.sv
`default_nettype none
// ============================================================================
//  Interface   : twiddle_factor_server_if
//  Description : Index request channel and coefficient response channel of
//                the twiddle-factor server, both valid/ready handshakes.
//                master : pointer-counter side (drives index, takes result)
//                slave  : server side
//  Revision    : 1.0 - initial release
// ============================================================================
interface twiddle_factor_server_if
    import twiddle_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = 16,
    parameter int IDX_W = idx_w(N)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [IDX_W-1:0]        in_index;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [IDX_W-1:0]        out_index;

    modport master (
        output in_valid, in_index, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index
    );

    modport slave (
        input  in_valid, in_index, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index
    );
endinterface
`default_nettype wire

// File: rtl/twiddle_quarter_rom.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_quarter_rom
//  Description : Quarter-wave cosine table, Q+1 entries (Q = N/4), with two
//                independent combinational read ports.
//  Ports       : a_re_i/a_im_i - table addresses 0..Q
//                re_o/im_o     - unsigned-valued signed table words
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_quarter_rom
    import twiddle_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = idx_w(N)
) (
    input  wire logic [ADDR_W-1:0]       a_re_i,
    input  wire logic [ADDR_W-1:0]       a_im_i,
    output logic signed [WIDTH-1:0]      re_o,
    output logic signed [WIDTH-1:0]      im_o
);
    localparam int c_q = N / 4;

    logic signed [WIDTH-1:0] w_table [0:c_q];

    for (genvar i = 0; i <= c_q; i++) begin : g_entry
        localparam logic signed [WIDTH-1:0] c_val = WIDTH'(cos_q(i, N, WIDTH));
        assign w_table[i] = c_val;
    end

    assign re_o = w_table[a_re_i];
    assign im_o = w_table[a_im_i];
endmodule
`default_nettype wire

// File: rtl/twiddle_factor_server.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_factor_server
//  Description : Two-stage pipelined lookup of W_N^k = cos - j*sin for
//                k in [0, N/2). S1 folds k onto the quarter-wave table
//                (addresses + negate flags); S2 reads, negates and drives the
//                outputs. Up to two transactions are held under backpressure.
//  Ports       : clk, reset (sync, active-high)
//                bus (slave) - in_valid/in_ready/in_index,
//                              out_valid/out_ready/out_re/out_im/out_index
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_factor_server
    import twiddle_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = 16,
    parameter int IDX_W = idx_w(N)
) (
    input  wire logic               clk,
    input  wire logic               reset,
    twiddle_factor_server_if.slave  bus
);
    localparam logic [IDX_W-1:0] c_q_idx = IDX_W'(N / 4);

    // Fold: Q is 2^(IDX_W-1), so the index MSB selects the upper quadrant
    // and the remaining bits are m. The two addresses are m and Q-m, swapped
    // between quadrants.
    logic             w_upper;
    logic [IDX_W-1:0] w_m;
    logic [IDX_W-1:0] w_q_minus_m;

    assign w_upper     = bus.in_index[IDX_W-1];
    assign w_m         = {1'b0, bus.in_index[IDX_W-2:0]};
    assign w_q_minus_m = c_q_idx - w_m;

    // Ready chain
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic w_s2_load, w_s1_adv, w_in_ready;

    assign w_s2_load    = ~s2_valid_q | bus.out_ready;
    assign w_s1_adv     = s1_valid_q & w_s2_load;
    assign w_in_ready   = ~s1_valid_q | w_s1_adv;
    assign bus.in_ready = w_in_ready;

    // Stage 1: folded addresses and sign flags
    logic [IDX_W-1:0] s1_index_q, s1_index_d;
    logic [IDX_W-1:0] s1_a_re_q,  s1_a_re_d;
    logic [IDX_W-1:0] s1_a_im_q,  s1_a_im_d;
    logic             s1_neg_re_q, s1_neg_re_d;
    logic             s1_neg_im_q, s1_neg_im_d;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_index_d  = s1_index_q;
        s1_a_re_d   = s1_a_re_q;
        s1_a_im_d   = s1_a_im_q;
        s1_neg_re_d = s1_neg_re_q;
        s1_neg_im_d = s1_neg_im_q;
        if (w_in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_index_d  = bus.in_index;
                s1_a_re_d   = w_upper ? w_q_minus_m : w_m;
                s1_a_im_d   = w_upper ? w_m : w_q_minus_m;
                s1_neg_re_d = w_upper;
                // sin >= 0 over the whole half circle, so Im is always negated
                s1_neg_im_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_index_q  <= '0;
            s1_a_re_q   <= '0;
            s1_a_im_q   <= '0;
            s1_neg_re_q <= 1'b0;
            s1_neg_im_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_index_q  <= s1_index_d;
            s1_a_re_q   <= s1_a_re_d;
            s1_a_im_q   <= s1_a_im_d;
            s1_neg_re_q <= s1_neg_re_d;
            s1_neg_im_q <= s1_neg_im_d;
        end
    end

    // Stage 2: table read and conditional negation
    logic signed [WIDTH-1:0] w_rom_re, w_rom_im;

    twiddle_quarter_rom #(
        .N      (N),
        .WIDTH  (WIDTH),
        .ADDR_W (IDX_W)
    ) u_rom (
        .a_re_i (s1_a_re_q),
        .a_im_i (s1_a_im_q),
        .re_o   (w_rom_re),
        .im_o   (w_rom_im)
    );

    logic signed [WIDTH-1:0] s2_re_q, s2_re_d;
    logic signed [WIDTH-1:0] s2_im_q, s2_im_d;
    logic [IDX_W-1:0]        s2_index_q, s2_index_d;

    // Table words are never negative, so negating zero yields plain zero.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_re_d    = s2_re_q;
        s2_im_d    = s2_im_q;
        s2_index_d = s2_index_q;
        if (w_s2_load) begin
            s2_valid_d = s1_valid_q;
            if (w_s1_adv) begin
                s2_re_d    = s1_neg_re_q ? -w_rom_re : w_rom_re;
                s2_im_d    = s1_neg_im_q ? -w_rom_im : w_rom_im;
                s2_index_d = s1_index_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
            s2_index_q <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_re_q    <= s2_re_d;
            s2_im_q    <= s2_im_d;
            s2_index_q <= s2_index_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_re    = s2_re_q;
    assign bus.out_im    = s2_im_q;
    assign bus.out_index = s2_index_q;
endmodule
`default_nettype wire

// File: tb/tb_twiddle_factor_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_factor_server
//  Description : Self-checking bench for twiddle_factor_server. Three
//                instances (N=8/W=16, N=16/W=16, N=64/W=12) share clock and
//                reset. A scoreboard per instance compares every output with
//                a golden value taken straight from cos/sin of the full angle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_factor_server;
    import twiddle_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    twiddle_factor_server_if #(.N(8),  .WIDTH(16)) ifa ();
    twiddle_factor_server_if #(.N(16), .WIDTH(16)) ifb ();
    twiddle_factor_server_if #(.N(64), .WIDTH(12)) ifc ();

    twiddle_factor_server #(.N(8),  .WIDTH(16)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    twiddle_factor_server #(.N(16), .WIDTH(16)) u_b (.clk(clk), .reset(reset), .bus(ifb));
    twiddle_factor_server #(.N(64), .WIDTH(12)) u_c (.clk(clk), .reset(reset), .bus(ifc));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint rnd(input real x);
        if (x >= 0.0) return longint'($rtoi(x + 0.5));
        return -longint'($rtoi(0.5 - x));
    endfunction

    function automatic coef_pair_t golden(input int k, input int n, input int w);
        coef_pair_t g;
        real s;
        real a;
        s    = real'((1 << (w - 1)) - 1);
        a    = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
        g.re = 32'(rnd($cos(a) * s));
        g.im = 32'(rnd(-$sin(a) * s));
        return g;
    endfunction

    // Scoreboard: queue of accepted indices per instance
    int     q [3][$];
    int     nn [3] = '{8, 16, 64};
    int     ww [3] = '{16, 16, 12};
    bit     held [3];
    longint prev_re [3];
    longint prev_im [3];
    longint prev_idx [3];

    task automatic score(input int id, input logic iv, input logic ir, input int ii,
                         input logic ov, input logic ordy,
                         input longint ore, input longint oim, input longint oidx);
        coef_pair_t g;
        if (reset) begin
            q[id].delete();
            held[id] = 1'b0;
            return;
        end
        check($sformatf("in_ready[%0d]", id), longint'(ir),
              longint'(!(q[id].size() == 2 && !ordy)));
        if (held[id]) begin
            check($sformatf("hold_valid[%0d]", id), longint'(ov), 1);
            check($sformatf("hold_re[%0d]", id), ore, prev_re[id]);
            check($sformatf("hold_im[%0d]", id), oim, prev_im[id]);
            check($sformatf("hold_idx[%0d]", id), oidx, prev_idx[id]);
        end
        if (ov === 1'b1) begin
            if (q[id].size() == 0) begin
                check($sformatf("spurious_out_idx[%0d]", id), oidx, -1);
            end else begin
                g = golden(q[id][0], nn[id], ww[id]);
                check($sformatf("out_index[%0d]", id), oidx, longint'(q[id][0]));
                check($sformatf("out_re[%0d] k=%0d", id, q[id][0]), ore, longint'(g.re));
                check($sformatf("out_im[%0d] k=%0d", id, q[id][0]), oim, longint'(g.im));
                check($sformatf("im_nonpos[%0d]", id), longint'(oim <= 0), 1);
                if (ordy) void'(q[id].pop_front());
            end
        end
        held[id]     = (ov === 1'b1) && !ordy;
        prev_re[id]  = ore;
        prev_im[id]  = oim;
        prev_idx[id] = oidx;
        if (iv && ir) q[id].push_back(ii);
    endtask

    // Scoreboard sampling, 1 time unit before each rising edge
    always begin
        @(negedge clk);
        #4;
        score(0, ifa.in_valid, ifa.in_ready, int'(ifa.in_index), ifa.out_valid, ifa.out_ready,
              longint'(ifa.out_re), longint'(ifa.out_im), longint'(ifa.out_index));
        score(1, ifb.in_valid, ifb.in_ready, int'(ifb.in_index), ifb.out_valid, ifb.out_ready,
              longint'(ifb.out_re), longint'(ifb.out_im), longint'(ifb.out_index));
        score(2, ifc.in_valid, ifc.in_ready, int'(ifc.in_index), ifc.out_valid, ifc.out_ready,
              longint'(ifc.out_re), longint'(ifc.out_im), longint'(ifc.out_index));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int exp_re8 [4] = '{32767, 23170, 0, -23170};
    int exp_im8 [4] = '{0, -23170, -32767, -23170};
    int seq16 [9]   = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int sent, got, stall, acc;
    bit saw_low;

    initial begin
        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_index = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_index = '0; ifb.out_ready = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_index = '0; ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", longint'(ifa.out_valid), 0);
        check("rst_out_re", longint'(ifa.out_re), 0);
        check("rst_out_im", longint'(ifa.out_im), 0);
        check("rst_out_index", longint'(ifa.out_index), 0);
        check("rst_in_ready", longint'(ifa.in_ready), 1);
        @(negedge clk);

        // N=8 back-to-back 0..3: one result per cycle after the pipeline fills
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifa.in_valid = (i < 4);
            ifa.in_index = (i < 4) ? 2'(i) : 2'd0;
            @(posedge clk); #1;
            if (i >= 1 && i <= 4) begin
                check($sformatf("b2b_valid_%0d", i), longint'(ifa.out_valid), 1);
                check($sformatf("b2b_index_%0d", i), longint'(ifa.out_index), longint'(i - 1));
                check($sformatf("b2b_re_%0d", i), longint'(ifa.out_re), longint'(exp_re8[i-1]));
                check($sformatf("b2b_im_%0d", i), longint'(ifa.out_im), longint'(exp_im8[i-1]));
            end else begin
                check($sformatf("b2b_idle_%0d", i), longint'(ifa.out_valid), 0);
            end
            @(negedge clk);
        end

        // N=16 sweep 0..7 then wrap to 0
        ifb.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ifb.in_valid = (i < 9);
            ifb.in_index = (i < 9) ? seq16[i][2:0] : 3'd0;
            @(posedge clk); #1;
            if (i >= 1) begin
                check($sformatf("sweep_valid_%0d", i), longint'(ifb.out_valid), 1);
                check($sformatf("sweep_index_%0d", i), longint'(ifb.out_index), longint'(seq16[i-1]));
                if (i == 5) begin
                    check("sweep_k4_re", longint'(ifb.out_re), 0);
                    check("sweep_k4_im", longint'(ifb.out_im), -32767);
                end
                if (i == 7) begin
                    check("sweep_k6_re", longint'(ifb.out_re), -23170);
                    check("sweep_k6_im", longint'(ifb.out_im), -23170);
                end
                if (i == 9) begin
                    check("sweep_wrap_re", longint'(ifb.out_re), 32767);
                    check("sweep_wrap_im", longint'(ifb.out_im), 0);
                end
            end
            @(negedge clk);
        end
        ifb.in_valid = 1'b0;

        // Backpressure on N=8: out_ready low for 5 cycles after the first output
        sent = 0; got = 0; stall = -1; saw_low = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (stall < 0 && ifa.out_valid) stall = 5;
            ifa.out_ready = (stall <= 0);
            ifa.in_valid  = (sent < 4);
            ifa.in_index  = sent[1:0];
            #1;
            if (ifa.in_valid && ifa.in_ready) sent++;
            if (!ifa.in_ready) saw_low = 1'b1;
            if (ifa.out_valid && ifa.out_ready) got++;
            if (stall > 0) stall--;
            @(negedge clk);
        end
        ifa.in_valid = 1'b0;
        check("bp_ready_fell", longint'(saw_low), 1);
        check("bp_sent", sent, 4);
        check("bp_received", got, 4);
        check("bp_queue_empty", q[0].size(), 0);

        // Reset with both stages full; an index offered during reset is ignored
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_index = 2'd2;
        @(negedge clk);
        ifa.in_index = 2'd3;
        @(negedge clk);
        check("full_in_ready", longint'(ifa.in_ready), 0);
        check("full_out_valid", longint'(ifa.out_valid), 1);
        reset = 1'b1; ifa.in_index = 2'd0;
        @(negedge clk);
        reset = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", longint'(ifa.out_valid), 0);
        check("mid_rst_out_re", longint'(ifa.out_re), 0);
        check("mid_rst_out_im", longint'(ifa.out_im), 0);
        check("mid_rst_in_ready", longint'(ifa.in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("mid_rst_no_stale_%0d", i), longint'(ifa.out_valid), 0);
        end
        ifa.in_valid = 1'b1; ifa.in_index = 2'd1;
        @(posedge clk); #1;
        check("post_rst_lat1", longint'(ifa.out_valid), 0);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", longint'(ifa.out_valid), 1);
        check("post_rst_re", longint'(ifa.out_re), 23170);
        check("post_rst_im", longint'(ifa.out_im), -23170);
        check("post_rst_index", longint'(ifa.out_index), 1);
        @(negedge clk);

        // Random handshakes on N=64, WIDTH=12
        acc = 0;
        for (int cyc = 0; cyc < 20000 && acc < 2000; cyc++) begin
            ifc.in_valid  = 1'($urandom_range(0, 1));
            ifc.in_index  = 5'($urandom_range(0, 31));
            ifc.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (ifc.in_valid && ifc.in_ready) acc++;
            @(negedge clk);
        end
        check("rand_accepted", acc, 2000);
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && q[2].size() != 0; cyc++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        check("rand_drained", q[2].size(), 0);
        check("rand_idle_valid", longint'(ifc.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
